// File: rtl/usb_uart_in_arb_pkg.sv
// rtl/usb_uart_in_arb_pkg.sv - shared state encoding, counter widths and defaults for the to-host byte arbiter
package usb_uart_in_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DROP  = 2'd2
    } arb_state_e;

    localparam int BURST_W          = 8;
    localparam int IDLE_W           = 16;
    localparam int DROP_W           = 16;
    localparam int DEF_MAX_BURST    = 64;
    localparam int DEF_IDLE_TIMEOUT = 4800;

    // Round-robin successor: the requester after the last owner gets first pick.
    function automatic logic [2:0] rr_next(input logic [2:0] cur, input int num_req);
        return (int'(cur) >= num_req - 1) ? 3'd0 : cur + 3'd1;
    endfunction

endpackage

// File: rtl/usb_rr_picker.sv
// rtl/usb_rr_picker.sv - first set request at or after the round-robin pointer, plus any-valid
module usb_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic [2:0]         pick_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [2:0]           off;
    logic [3:0]           sum;

    always_comb begin
        // Rotate so the pointer lands on bit 0, priority-encode, then rotate back.
        dbl = {req_i, req_i};
        rot = dbl[ptr_i +: NUM_REQ];
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = 3'(k);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= 4'(NUM_REQ)) begin
            sum = sum - 4'(NUM_REQ);
        end
        pick_o = sum[2:0];
        any_o  = |req_i;
    end

endmodule

// File: rtl/usb_uart_in_arb.sv
// rtl/usb_uart_in_arb.sv - message-granular round-robin arbiter onto the usb_uart to-host byte stream
module usb_uart_in_arb
    import usb_uart_in_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                 clk_48mhz,
    input  logic                 reset_n,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 host_present,
    output logic [7:0]           uart_in_data,
    output logic                 uart_in_valid,
    input  logic                 uart_in_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic [DROP_W-1:0]    drop_count
);

    arb_state_e          state_q, state_d;
    logic [2:0]          grant_q, grant_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic [2:0]          pick;
    logic                any_valid;
    logic                g_valid, g_last, xfer;
    logic [7:0]          g_data;
    logic [3:0]          vcnt;
    logic [DROP_W:0]     drop_sum;

    usb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i  (req_valid),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .any_o  (any_valid)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        burst_d       = burst_q;
        idle_d        = idle_q;
        drop_d        = drop_q;
        req_ready     = '0;
        uart_in_valid = 1'b0;
        uart_in_data  = '0;
        g_valid       = 1'b0;
        g_last        = 1'b0;
        g_data        = '0;
        xfer          = 1'b0;
        vcnt          = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            vcnt = vcnt + {3'b000, req_valid[i]};
            if (3'(i) == grant_q) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[8*i +: 8];
            end
        end
        drop_sum = {1'b0, drop_q} + {{(DROP_W-3){1'b0}}, vcnt};

        case (state_q)
            ST_IDLE: begin
                if (!host_present) begin
                    state_d = ST_DROP;
                end else if (any_valid) begin
                    grant_d = pick;
                    burst_d = '0;
                    idle_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                uart_in_valid = g_valid;
                uart_in_data  = g_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (3'(i) == grant_q) begin
                        req_ready[i] = uart_in_ready;
                    end
                end
                xfer   = g_valid && uart_in_ready;
                idle_d = g_valid ? '0 : idle_q + 1'b1;
                if (xfer) begin
                    burst_d = burst_q + 1'b1;
                end
                // Losing the host wins over a normal exit; the in-flight byte still goes out.
                if (!host_present) begin
                    state_d = ST_DROP;
                end else if ((xfer && (g_last || burst_q == BURST_W'(MAX_BURST - 1))) ||
                             (!g_valid && idle_q == IDLE_W'(IDLE_TIMEOUT - 1))) begin
                    state_d = ST_IDLE;
                    ptr_d   = rr_next(grant_q, NUM_REQ);
                end
            end
            ST_DROP: begin
                req_ready = '1;
                drop_d    = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
                if (host_present) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            idle_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            drop_q  <= drop_d;
        end
    end

    assign grant_id   = grant_q;
    assign busy       = (state_q == ST_GRANT);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_usb_uart_in_arb.sv
// tb/tb_usb_uart_in_arb.sv - scoreboard bench for usb_uart_in_arb
module tb_usb_uart_in_arb;

    localparam int NREQ = 4;
    localparam int MB   = 4;
    localparam int IT   = 50;

    logic              clk_48mhz = 1'b0;
    logic              reset_n = 1'b0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              host_present = 1'b1;
    logic [7:0]        uart_in_data;
    logic              uart_in_valid;
    logic              uart_in_ready = 1'b0;
    logic [2:0]        grant_id;
    logic              busy;
    logic [15:0]       drop_count;

    always #5 clk_48mhz = ~clk_48mhz;

    usb_uart_in_arb #(.NUM_REQ(NREQ), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
        .clk_48mhz     (clk_48mhz),
        .reset_n       (reset_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .host_present  (host_present),
        .uart_in_data  (uart_in_data),
        .uart_in_valid (uart_in_valid),
        .uart_in_ready (uart_in_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .drop_count    (drop_count)
    );

    logic [8:0]      prod_q [NREQ][$];
    logic [8:0]      exp_q  [NREQ][$];
    int              ord_q [$];
    logic [NREQ-1:0] hs_v = '0;
    bit              dir_mode = 1'b1;
    bit              rdy_low = 1'b0;
    bit              rdy_rand = 1'b0;
    bit              gap_rand = 1'b0;
    int              checks = 0;
    int              errors = 0;
    int              tb_drops = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_msg(input int src, input int n, input bit with_last);
        logic [8:0] e;
        for (int k = 0; k < n; k++) begin
            e[7:0] = 8'($urandom);
            e[8]   = with_last && (k == n - 1);
            prod_q[src].push_back(e);
            exp_q[src].push_back(e);
        end
    endtask

    task automatic push_ord(input int src, input int n);
        repeat (n) ord_q.push_back(src);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (prod_q[i].size() != 0) return 1'b0;
        return ord_q.size() == 0;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (n < budget && !all_empty()) begin
            @(negedge clk_48mhz);
            #3;
            n++;
        end
        chk({name, "_done"}, int'(n < budget), 1);
    endtask

    task automatic do_reset();
        @(negedge clk_48mhz);
        reset_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            prod_q[i].delete();
            exp_q[i].delete();
        end
        ord_q.delete();
        tb_drops = 0;
        repeat (2) @(negedge clk_48mhz);
        reset_n = 1'b1;
        #3;
    endtask

    // Producers and the host-side ready: present the head of each queue, pop on last cycle's handshake.
    always @(negedge clk_48mhz) begin
        for (int i = 0; i < NREQ; i++)
            if (hs_v[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
        for (int i = 0; i < NREQ; i++) begin
            if (prod_q[i].size() > 0 && (!gap_rand || $urandom_range(3) != 0)) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = prod_q[i][0][7:0];
                req_last[i]        = prod_q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        uart_in_ready = !rdy_low && (!rdy_rand || $urandom_range(3) != 0);
    end

    // Monitor: every consumed byte is either delivered by the owner or dropped, in producer order.
    always @(negedge clk_48mhz) begin : mon
        logic [8:0] e;
        bit         xfer;
        int         o;
        #2;
        hs_v = req_valid & req_ready;
        if (reset_n) begin
            xfer = uart_in_valid && uart_in_ready;
            if (!busy && uart_in_valid) chk("valid_outside_grant", 1, 0);
            if (busy)
                for (int i = 0; i < NREQ; i++)
                    if (i != int'(grant_id) && req_ready[i]) chk("ready_isolation", i, int'(grant_id));
            for (int i = 0; i < NREQ; i++) begin
                if (hs_v[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk("spurious_consume", i, -1);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (xfer && int'(grant_id) == i) begin
                            chk("out_data", int'(uart_in_data), int'(e[7:0]));
                        end else begin
                            tb_drops++;
                            chk("drop_while_busy", int'(busy), 0);
                        end
                    end
                end
            end
            if (xfer) begin
                if (ord_q.size() > 0) begin
                    o = ord_q.pop_front();
                    chk("order", int'(grant_id), o);
                end else if (dir_mode) begin
                    chk("order_extra", int'(grant_id), -1);
                end
            end
        end
    end

    initial begin
        int n;

        do_reset();
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_valid", int'(uart_in_valid), 0);
        chk("rst_data", int'(uart_in_data), 0);
        chk("rst_grant", int'(grant_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_count), 0);

        // 3-byte message from req0, then pointer has moved to req1
        @(posedge clk_48mhz);
        push_msg(0, 3, 1'b1); push_ord(0, 3);
        wait_done("t_single", 100);
        chk("t_single_busy_after_last", int'(busy), 0);
        @(posedge clk_48mhz);
        push_msg(0, 2, 1'b1); push_msg(1, 2, 1'b1);
        push_ord(1, 2); push_ord(0, 2);
        wait_done("t_ptr_next", 100);

        // three simultaneous messages, not interleaved
        do_reset();
        @(posedge clk_48mhz);
        push_msg(0, 2, 1'b1); push_msg(1, 2, 1'b1); push_msg(2, 2, 1'b1);
        push_ord(0, 2); push_ord(1, 2); push_ord(2, 2);
        wait_done("t_three", 100);

        // byte budget rotation
        do_reset();
        @(posedge clk_48mhz);
        push_msg(1, 10, 1'b0); push_msg(3, 2, 1'b1);
        push_ord(1, 4); push_ord(3, 2); push_ord(1, 6);
        wait_done("t_budget", 200);
        chk("t_budget_hold_busy", int'(busy), 1);
        chk("t_budget_hold_grant", int'(grant_id), 1);

        // idle timeout revokes req2, req0 served, req2 resumes afterwards
        do_reset();
        @(posedge clk_48mhz);
        push_msg(2, 1, 1'b0); push_ord(2, 1);
        wait_done("t_to_first", 50);
        push_msg(0, 2, 1'b1); push_ord(0, 2);
        n = 0;
        while (busy && grant_id == 3'd2 && n < 3 * IT) begin
            n++;
            @(negedge clk_48mhz);
            #3;
        end
        chk("t_to_hold_cycles", n, IT);
        push_msg(2, 1, 1'b1); push_ord(2, 1);
        wait_done("t_to_resume", 100);

        // host-side stall mid-message
        do_reset();
        @(posedge clk_48mhz);
        push_msg(0, 4, 1'b1); push_ord(0, 4);
        n = 0;
        while (prod_q[0].size() > 2 && n < 50) begin
            n++;
            @(negedge clk_48mhz);
            #3;
        end
        rdy_low = 1'b1;
        repeat (20) begin
            @(negedge clk_48mhz);
            #3;
            chk("stall_valid", int'(uart_in_valid), 1);
            if (prod_q[0].size() > 0) chk("stall_data", int'(uart_in_data), int'(prod_q[0][0][7:0]));
            chk("stall_req_ready", int'(req_ready), 0);
        end
        rdy_low = 1'b0;
        wait_done("t_stall", 50);
        chk("stall_no_drop", int'(drop_count), 0);

        // drop mode: two producers for 100 cycles, then host returns
        do_reset();
        host_present = 1'b0;
        @(posedge clk_48mhz);
        push_msg(0, 100, 1'b0); push_msg(1, 100, 1'b0);
        wait_done("t_drop", 300);
        chk("t_drop_count", int'(drop_count), 200);
        host_present = 1'b1;
        @(posedge clk_48mhz);
        push_msg(1, 2, 1'b1); push_ord(1, 2);
        wait_done("t_drop_resume", 100);

        // randomized traffic with host loss windows and random host ready
        do_reset();
        dir_mode = 1'b0; rdy_rand = 1'b1; gap_rand = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk_48mhz);
            host_present = (cyc % 600) < 560;
            if ($urandom_range(7) == 0) begin
                n = int'($urandom_range(NREQ - 1));
                if (prod_q[n].size() < 8) push_msg(n, int'($urandom_range(6, 1)), 1'b1);
            end
        end
        host_present = 1'b1;
        wait_done("t_rand", 3000);
        chk("t_rand_drop_count", int'(drop_count), tb_drops);

        // drop counter saturation
        do_reset();
        dir_mode = 1'b1; rdy_rand = 1'b0; gap_rand = 1'b0;
        host_present = 1'b0;
        @(posedge clk_48mhz);
        for (int i = 0; i < NREQ; i++) push_msg(i, 16400, 1'b0);
        wait_done("t_sat", 17000);
        chk("t_sat_drop_count", int'(drop_count), 65535);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
